// File: rtl/ad7476a_sample_averager.sv
// Windowed averager for AD7476A samples: accumulates 2^LOG2_AVG samples and
// emits rounded mean, minimum and maximum through a valid/ready register.
module ad7476a_sample_averager #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned LOG2_AVG   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] avg_o,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o
);

  localparam int unsigned ACC_W = DATA_WIDTH + LOG2_AVG;
  localparam logic [ACC_W-1:0] ROUND = ACC_W'((1 << LOG2_AVG) >> 1);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  out_state_e            out_state_q;
  logic [ACC_W-1:0]      acc_q;
  logic [DATA_WIDTH-1:0] run_min_q;
  logic [DATA_WIDTH-1:0] run_max_q;

  logic                  win_last_c;
  logic                  accept_c;
  logic                  win_done_c;
  logic [ACC_W-1:0]      acc_next_c;
  logic [ACC_W-1:0]      sum_rnd_c;
  logic [DATA_WIDTH-1:0] avg_c;
  logic [DATA_WIDTH-1:0] min_next_c;
  logic [DATA_WIDTH-1:0] max_next_c;

  // Position within the window; with a window of one every sample is the last.
  if (LOG2_AVG > 0) begin : g_cnt
    logic [LOG2_AVG-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        cnt_q <= '0;
      end else if (sample_valid_i) begin
        cnt_q <= cnt_q + LOG2_AVG'(1);
      end
    end

    assign win_last_c = (cnt_q == {LOG2_AVG{1'b1}});
  end else begin : g_nocnt
    assign win_last_c = 1'b1;
  end

  // Next accumulator and extrema include the incoming sample so the
  // completing sample is part of its own window result.
  always_comb begin
    accept_c   = sample_valid_i && !clear_i;
    win_done_c = accept_c && win_last_c;
    acc_next_c = acc_q + ACC_W'(sample_i);
    sum_rnd_c  = acc_next_c + ROUND;
    avg_c      = DATA_WIDTH'(sum_rnd_c >> LOG2_AVG);
    min_next_c = (sample_i < run_min_q) ? sample_i : run_min_q;
    max_next_c = (sample_i > run_max_q) ? sample_i : run_max_q;
  end

  // Window accumulation state.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || win_done_c) begin
      acc_q     <= '0;
      run_min_q <= '1;
      run_max_q <= '0;
    end else if (accept_c) begin
      acc_q     <= acc_next_c;
      run_min_q <= min_next_c;
      run_max_q <= max_next_c;
    end
  end

  // Result register: loads when empty or being drained, otherwise the new
  // result is dropped and the overrun flag latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_state_q <= OUT_EMPTY;
      avg_o       <= '0;
      min_o       <= '0;
      max_o       <= '0;
      overrun_o   <= 1'b0;
    end else begin
      if (clear_i) begin
        overrun_o <= 1'b0;
      end
      case (out_state_q)
        OUT_EMPTY: begin
          if (win_done_c) begin
            out_state_q <= OUT_FULL;
            avg_o       <= avg_c;
            min_o       <= min_next_c;
            max_o       <= max_next_c;
          end
        end
        OUT_FULL: begin
          if (win_done_c) begin
            if (ready_i) begin
              avg_o <= avg_c;
              min_o <= min_next_c;
              max_o <= max_next_c;
            end else begin
              overrun_o <= 1'b1;
            end
          end else if (ready_i) begin
            out_state_q <= OUT_EMPTY;
          end
        end
        default: out_state_q <= OUT_EMPTY;
      endcase
    end
  end

  assign valid_o = (out_state_q == OUT_FULL);

endmodule

// File: tb/tb_ad7476a_sample_averager.sv
// Bench for ad7476a_sample_averager: directed windows plus randomized traffic
// against a window-level reference model; a second instance covers LOG2_AVG=0.
module tb_ad7476a_sample_averager;

  localparam int unsigned DW = 12;
  localparam int unsigned L2 = 4;
  localparam int unsigned N  = 1 << L2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample = '0;
  logic          sample_valid = 1'b0;
  logic          clear = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] avg, mn, mx;
  logic          valid, ovr;

  logic [DW-1:0] sample0 = '0;
  logic          sample_valid0 = 1'b0;
  logic [DW-1:0] avg0, mn0, mx0;
  logic          valid0, ovr0;

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open window, plus the result register.
  int win_q[$];
  bit m_valid;
  int m_avg, m_min, m_max;
  bit m_ovr;

  always #5 clk = ~clk;

  ad7476a_sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(L2)) dut (
    .clk_i(clk), .rst_i(rst), .sample_i(sample), .sample_valid_i(sample_valid),
    .clear_i(clear), .avg_o(avg), .min_o(mn), .max_o(mx), .valid_o(valid),
    .ready_i(ready), .overrun_o(ovr)
  );

  ad7476a_sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .sample_i(sample0), .sample_valid_i(sample_valid0),
    .clear_i(1'b0), .avg_o(avg0), .min_o(mn0), .max_o(mx0), .valid_o(valid0),
    .ready_i(1'b1), .overrun_o(ovr0)
  );

  function automatic void model_reset();
    win_q.delete();
    m_valid = 0; m_avg = 0; m_min = 0; m_max = 0; m_ovr = 0;
  endfunction

  // Drive one clock of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit r, input bit sv, input int s, input bit clr, input bit rdy);
    bit done;
    int sum, a, lo, hi;
    rst = r; sample_valid = sv; sample = DW'(s); clear = clr; ready = rdy;
    done = 0;
    if (r) begin
      model_reset();
    end else begin
      if (clr) begin
        win_q.delete();
        m_ovr = 0;
      end else if (sv) begin
        win_q.push_back(s);
        if (win_q.size() == N) begin
          done = 1;
          sum = 0; lo = win_q[0]; hi = win_q[0];
          foreach (win_q[i]) begin
            sum += win_q[i];
            if (win_q[i] < lo) lo = win_q[i];
            if (win_q[i] > hi) hi = win_q[i];
          end
          a = (sum + N / 2) / N;
          win_q.delete();
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_valid = 1; m_avg = a; m_min = lo; m_max = hi;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int s, input int count, input bit rdy);
    for (int i = 0; i < count; i++) cycle(0, 1, s, 0, rdy);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (valid !== 1'b0 || ovr !== 1'b0 || avg !== '0 || mn !== '0 || mx !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b ovr=%0b avg=%0d min=%0d max=%0d, expected all 0",
               valid, ovr, avg, mn, mx);
    end
  endtask

  task automatic test_basic();
    feed(100, 15, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %0b expected 0", valid);
    end
    feed(100, 1, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd100 || mn !== 12'd100 || mx !== 12'd100) begin
      errors++;
      $display("FAIL basic_result: valid=%0b avg=%0d min=%0d max=%0d expected 1/100/100/100",
               valid, avg, mn, mx);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: valid=%0b expected 0", valid);
    end
  endtask

  task automatic test_rounding();
    feed(0, 8, 1);
    feed(1, 8, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd1) begin
      errors++; $display("FAIL round_half_up: valid=%0b avg=%0d expected 1/1", valid, avg);
    end
    feed(1, 7, 1);
    feed(0, 9, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd0 || mn !== 12'd0 || mx !== 12'd1) begin
      errors++;
      $display("FAIL round_down: valid=%0b avg=%0d min=%0d max=%0d expected 1/0/0/1",
               valid, avg, mn, mx);
    end
    feed(4095, 16, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd4095 || mn !== 12'd4095 || mx !== 12'd4095) begin
      errors++;
      $display("FAIL full_scale: valid=%0b avg=%0d min=%0d max=%0d expected 4095",
               valid, avg, mn, mx);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_mixed();
    feed(10, 1, 1);
    feed(4000, 1, 1);
    feed(37, 1, 1);
    feed(500, 13, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd659 || mn !== 12'd10 || mx !== 12'd4000) begin
      errors++;
      $display("FAIL mixed_window: valid=%0b avg=%0d min=%0d max=%0d expected 1/659/10/4000",
               valid, avg, mn, mx);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    feed(100, 16, 0);
    feed(200, 16, 0);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd100 || mx !== 12'd100 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: valid=%0b avg=%0d max=%0d ovr=%0b expected 1/100/100/1",
               valid, avg, mx, ovr);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (valid !== 1'b0 || avg !== 12'd100) begin
      errors++; $display("FAIL overrun_drain: valid=%0b avg=%0d expected 0/100", valid, avg);
    end
    feed(50, 16, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd50 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: valid=%0b avg=%0d ovr=%0b expected 1/50/1", valid, avg, ovr);
    end
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (ovr !== 1'b0 || valid !== 1'b1 || avg !== 12'd50) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%0b valid=%0b avg=%0d expected 0/1/50", ovr, valid, avg);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_clear();
    feed(999, 7, 1);
    cycle(0, 1, 999, 1, 1);
    feed(300, 15, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL clear_early: valid=%0b expected 0", valid);
    end
    feed(300, 1, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd300 || mx !== 12'd300) begin
      errors++;
      $display("FAIL clear_window: valid=%0b avg=%0d max=%0d expected 1/300/300", valid, avg, mx);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    feed(77, 16, 0);
    feed(500, 5, 0);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (valid !== 1'b0 || avg !== '0 || mn !== '0 || mx !== '0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b avg=%0d min=%0d max=%0d ovr=%0b expected all 0",
               valid, avg, mn, mx, ovr);
    end
    feed(123, 15, 1);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_early: valid=%0b expected 0", valid);
    end
    feed(123, 1, 1);
    checks++;
    if (valid !== 1'b1 || avg !== 12'd123 || mn !== 12'd123) begin
      errors++;
      $display("FAIL reset_mid_window: valid=%0b avg=%0d min=%0d expected 1/123/123",
               valid, avg, mn);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit sv, clr, rdy;
      int s;
      sv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 2) != 0);
      s   = (i % 300 < 40) ? 4095 : int'($urandom_range(0, 4095));
      cycle(0, sv, s, clr, rdy);
      checks++;
      if (valid !== m_valid || ovr !== m_ovr || avg !== DW'(m_avg) ||
          mn !== DW'(m_min) || mx !== DW'(m_max)) begin
        errors++;
        $display("FAIL random_cycle%0d: valid=%0b ovr=%0b avg=%0d min=%0d max=%0d, expected %0b %0b %0d %0d %0d",
                 i, valid, ovr, avg, mn, mx, m_valid, m_ovr, m_avg, m_min, m_max);
      end
    end
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_log2_zero();
    for (int i = 0; i < 10; i++) begin
      int s;
      s = int'($urandom_range(0, 4095));
      sample0 = DW'(s);
      sample_valid0 = 1'b1;
      cycle(0, 0, 0, 0, 1);
      checks++;
      if (valid0 !== 1'b1 || avg0 !== DW'(s) || mn0 !== DW'(s) || mx0 !== DW'(s)) begin
        errors++;
        $display("FAIL log2_zero_%0d: valid=%0b avg=%0d min=%0d max=%0d expected %0d",
                 i, valid0, avg0, mn0, mx0, s);
      end
    end
    sample_valid0 = 1'b0;
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (valid0 !== 1'b0) begin
      errors++; $display("FAIL log2_zero_drain: valid=%0b expected 0", valid0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_rounding();
    test_mixed();
    test_overrun();
    test_clear();
    test_reset_mid();
    test_random();
    test_log2_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
